// File: rtl/sc_hdlc_tx_sched.sv
// sc_hdlc_tx_sched: frame-atomic round-robin scheduler feeding one HDLC stream.
// Define SC_HDLC_TX_SCHED_TIMEOUT_EN to abort frames whose source stalls mid-frame.
module sc_hdlc_tx_sched #(
    parameter int N_SRC          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [8*N_SRC-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]   s_axis_tvalid,
    input  logic [N_SRC-1:0]   s_axis_tlast,
    output logic [N_SRC-1:0]   s_axis_tready,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic [4:0]         m_axis_tdest,
    output logic               m_axis_tuser,
    output logic [N_SRC-1:0]   grant,
    output logic               busy,
    output logic [31:0]        pkt_length,
    output logic               pkt_length_push
);

    localparam int IW = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] g, g_nxt;
    logic [IW-1:0] last_grant, last_nxt;
    logic [31:0]   byte_cnt, cnt_nxt, cnt_inc;
    logic [15:0]   gap_cnt, gap_nxt;
    logic [31:0]   len_nxt;
    logic          push_nxt;
    logic [7:0]    src_data;
    logic          src_valid, src_last, hs;
    logic [IW-1:0] pick;
    logic          pick_ok;

`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
    logic [31:0]   stall_cnt, stall_nxt;
`else
    logic [31:0]   unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        src_data  = s_axis_tdata[8*int'(g) +: 8];
        src_valid = s_axis_tvalid[g];
        src_last  = s_axis_tlast[g];
        hs        = (state == XFER) && src_valid && m_axis_tready;
        cnt_inc   = (byte_cnt == '1) ? byte_cnt : byte_cnt + 32'd1;
    end

    // Descending scan so the nearest index after last_grant wins.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = last_grant;
        pick_ok = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_SRC;
            if (s_axis_tvalid[idx]) begin
                pick    = IW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last_grant;
        cnt_nxt   = byte_cnt;
        gap_nxt   = gap_cnt;
        len_nxt   = pkt_length;
        push_nxt  = 1'b0;
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
        stall_nxt = stall_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (en && pick_ok) begin
                    g_nxt     = pick;
                    state_nxt = XFER;
                end
            end
            XFER: begin
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
                if (src_valid) begin
                    stall_nxt = '0;
                end else if (stall_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    stall_nxt = '0;
                    state_nxt = ABORT;
                end else begin
                    stall_nxt = stall_cnt + 32'd1;
                end
`endif
                if (hs) begin
                    cnt_nxt = cnt_inc;
                    if (src_last) begin
                        len_nxt   = cnt_inc;
                        push_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        last_nxt  = g;
                        gap_nxt   = '0;
                        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 16'(GAP_CYCLES - 1)) state_nxt = IDLE;
                else gap_nxt = gap_cnt + 16'd1;
            end
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
            ABORT: begin
                if (m_axis_tready) begin
                    len_nxt   = byte_cnt;
                    push_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    last_nxt  = g;
                    gap_nxt   = '0;
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tdest  = '0;
        grant         = '0;
        busy          = (state != IDLE);
        if (state == XFER) begin
            m_axis_tdata     = src_data;
            m_axis_tvalid    = src_valid;
            m_axis_tlast     = src_last;
            m_axis_tdest     = 5'(g);
            s_axis_tready[g] = m_axis_tready;
            grant[g]         = 1'b1;
        end
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
        if (state == ABORT) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            m_axis_tdest  = 5'(g);
            grant[g]      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            g               <= '0;
            last_grant      <= IW'(N_SRC - 1);
            byte_cnt        <= '0;
            gap_cnt         <= '0;
            pkt_length      <= '0;
            pkt_length_push <= 1'b0;
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
            stall_cnt       <= '0;
`endif
        end else begin
            state           <= state_nxt;
            g               <= g_nxt;
            last_grant      <= last_nxt;
            byte_cnt        <= cnt_nxt;
            gap_cnt         <= gap_nxt;
            pkt_length      <= len_nxt;
            pkt_length_push <= push_nxt;
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
            stall_cnt       <= stall_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sc_hdlc_tx_sched.sv
// tb_sc_hdlc_tx_sched: scoreboard bench for the HDLC tx scheduler.
// Source byte queues feed the DUT; expected beats/lengths are popped at the output.
module tb_sc_hdlc_tx_sched;

    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           en = 1'b1;
    logic [8*N-1:0] s_tdata = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tlast = '0;
    logic [N-1:0]   s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid, m_tlast, m_tuser;
    logic           m_ready = 1'b1;
    logic [4:0]     m_tdest;
    logic [N-1:0]   grant;
    logic           busy;
    logic [31:0]    pkt_length;
    logic           push;

    typedef struct packed {
        logic [4:0] dest;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned pkt_q[$];
    logic [8:0]  src_q[N][$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beats = 0;
    int last_cyc = 0;
    bit bp_mode = 1'b0;

    sc_hdlc_tx_sched #(
        .N_SRC(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast),
        .m_axis_tready(m_ready),
        .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser),
        .grant(grant),
        .busy(busy),
        .pkt_length(pkt_length),
        .pkt_length_push(push)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    // One cycle: drive at negedge, sample 1ns later, retire handshakes.
    task automatic cycle();
        beat_t e;
        logic [N-1:0] rdy_exp;
        int unsigned plen;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]       = 1'b1;
                s_tdata[8*i +: 8] = src_q[i][0][7:0];
                s_tlast[i]        = src_q[i][0][8];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]        = 1'b0;
            end
        end
        m_ready = bp_mode ? ~m_ready : 1'b1;
        #1;
        cyc++;
        if (m_tvalid && exp_q.size() > 0) begin
            e = exp_q[0];
            rdy_exp = '0;
            if (!e.user && m_ready) rdy_exp[e.dest[1:0]] = 1'b1;
            total++;
            if (s_tready !== rdy_exp) begin
                bad++;
                $display("FAIL tready_mirror cyc=%0d got=%b want=%b", cyc, s_tready, rdy_exp);
            end
        end
        if (m_tvalid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat cyc=%0d dest=%0d data=%h", cyc, m_tdest, m_tdata);
            end else begin
                e = exp_q.pop_front();
                if ({m_tdest, m_tdata, m_tlast, m_tuser} !== e) begin
                    bad++;
                    $display("FAIL beat cyc=%0d got dest=%0d data=%h last=%b user=%b want dest=%0d data=%h last=%b user=%b",
                             cyc, m_tdest, m_tdata, m_tlast, m_tuser, e.dest, e.data, e.last, e.user);
                end
                beats++;
                if (m_tlast) last_cyc = cyc;
            end
        end
        if (push) begin
            total++;
            if (pkt_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_push cyc=%0d len=%0d", cyc, pkt_length);
            end else begin
                plen = pkt_q.pop_front();
                if (pkt_length !== plen) begin
                    bad++;
                    $display("FAIL pkt_length cyc=%0d got=%0d want=%0d", cyc, pkt_length, plen);
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (s_tvalid[i] && s_tready[i]) void'(src_q[i].pop_front());
    endtask

    task automatic load_src(int s, int len, int base, bit with_last);
        for (int b = 0; b < len; b++)
            src_q[s].push_back({with_last && (b == len - 1), 8'(base + b)});
    endtask

    task automatic expect_frame(int s, int len, int base);
        for (int b = 0; b < len; b++)
            exp_q.push_back('{dest: 5'(s), data: 8'(base + b), last: (b == len - 1), user: 1'b0});
        pkt_q.push_back(len);
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pkt_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (exp_q.size() > 0 || pkt_q.size() > 0) begin
            bad++;
            $display("FAIL %s_stuck beats_left=%0d pkts_left=%0d", name, exp_q.size(), pkt_q.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) cycle();
        total++;
        if ({grant, busy, s_tready} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl grant=%b busy=%b tready=%b want all 0", grant, busy, s_tready);
        end
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, m_tdest} !== '0) begin
            bad++;
            $display("FAIL reset_mstream v=%b l=%b u=%b d=%h dest=%0d want all 0",
                     m_tvalid, m_tlast, m_tuser, m_tdata, m_tdest);
        end
        total++;
        if ({pkt_length, push} !== '0) begin
            bad++;
            $display("FAIL reset_stats len=%0d push=%b want 0", pkt_length, push);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int n;
        load_src(1, 5, 'h10, 1'b1);
        expect_frame(1, 5, 'h10);
        drain("single", 60);
        n = 0;
        while (busy && n < 40) begin
            cycle();
            n++;
        end
        total++;
        if (busy !== 1'b0 || cyc - last_cyc != GAP + 1) begin
            bad++;
            $display("FAIL single_gap busy=%b idle_after=%0d want busy=0 idle_after=%0d",
                     busy, cyc - last_cyc, GAP + 1);
        end
    endtask

    task automatic test_contention();
        rstn = 1'b0;
        cycle();
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < N; s++) load_src(s, 3, s * 16 + f * 4, 1'b1);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < N; s++) expect_frame(s, 3, s * 16 + f * 4);
        rstn = 1'b1;
        drain("contention", 300);
    endtask

    task automatic test_backpressure();
        repeat (GAP + 2) cycle();
        bp_mode = 1'b1;
        load_src(2, 4, 'h20, 1'b1);
        expect_frame(2, 4, 'h20);
        drain("backpressure", 80);
        bp_mode = 1'b0;
    endtask

    task automatic test_en_drop();
        int b0, n;
        repeat (GAP + 2) cycle();
        load_src(3, 6, 'h30, 1'b1);
        expect_frame(3, 6, 'h30);
        b0 = beats;
        n = 0;
        while (beats < b0 + 2 && n < 40) begin
            cycle();
            n++;
        end
        total++;
        if (beats < b0 + 2) begin
            bad++;
            $display("FAIL en_drop_start beats=%0d want=%0d", beats - b0, 2);
        end
        en = 1'b0;
        load_src(0, 2, 'h50, 1'b1);
        drain("en_drop", 60);
        repeat (GAP + 1) cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            total++;
            if (grant !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL en_low_grant cyc=%0d grant=%b busy=%b want 0", cyc, grant, busy);
            end
        end
        en = 1'b1;
        expect_frame(0, 2, 'h50);
        drain("en_resume", 40);
    endtask

    task automatic test_reset_mid();
        int b0, n;
        repeat (GAP + 2) cycle();
        load_src(2, 6, 'h60, 1'b1);
        expect_frame(2, 6, 'h60);
        b0 = beats;
        n = 0;
        while (beats < b0 + 3 && n < 40) begin
            cycle();
            n++;
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({grant, busy, s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tdest} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs grant=%b busy=%b tready=%b v=%b l=%b u=%b d=%h dest=%0d want all 0",
                     grant, busy, s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tdest);
        end
        total++;
        if ({pkt_length, push} !== '0) begin
            bad++;
            $display("FAIL midreset_stats len=%0d push=%b want 0", pkt_length, push);
        end
        exp_q.delete();
        pkt_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (3) cycle();
        rstn = 1'b1;
        for (int s = N - 1; s >= 0; s--) load_src(s, 2, 'h80 + s * 16, 1'b1);
        for (int s = 0; s < N; s++) expect_frame(s, 2, 'h80 + s * 16);
        drain("after_reset", 120);
    endtask

`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        repeat (GAP + 2) cycle();
        load_src(2, 2, 'h70, 1'b0);
        exp_q.push_back('{dest: 5'd2, data: 8'h70, last: 1'b0, user: 1'b0});
        exp_q.push_back('{dest: 5'd2, data: 8'h71, last: 1'b0, user: 1'b0});
        exp_q.push_back('{dest: 5'd2, data: 8'h00, last: 1'b1, user: 1'b1});
        pkt_q.push_back(2);
        drain("timeout", 60);
        total++;
        if (busy !== 1'b1 || grant !== '0) begin
            bad++;
            $display("FAIL timeout_gap busy=%b grant=%b want busy=1 grant=0", busy, grant);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_en_drop();
        test_reset_mid();
`ifdef SC_HDLC_TX_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
